dmem_arbiter: RTL and testbench

- Two-requester arbiter in front of the data memory.
- Shares the single memory port between the pipeline MEM stage (port C, the CPU) and a program/debug loader (port L).
- Grants one access per cycle, round-robin. Returns read data one cycle after acceptance with a valid pulse.
- Gives the pipeline a stall indication whenever its access is not granted.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle: CPU (c_*) and loader (l_*) request/response
// channels plus the shared single memory port (mem_*).
//   slave  : arbiter view (takes requests, drives responses and the memory port)
//   master : environment view (requesters and memory model)
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // CPU (pipeline MEM stage) port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ready;
  logic              c_stall;
  logic [DATA_W-1:0] c_rdata;
  logic              c_rvalid;

  // Program/debug loader port
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_ready;
  logic [DATA_W-1:0] l_rdata;
  logic              l_rvalid;

  // Shared memory port (memory read is combinational)
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_ready, c_stall, c_rdata, c_rvalid,
    input  l_req, l_we, l_addr, l_wdata,
    output l_ready, l_rdata, l_rvalid,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_ready, c_stall, c_rdata, c_rvalid,
    output l_req, l_we, l_addr, l_wdata,
    input  l_ready, l_rdata, l_rvalid,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the data memory.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : dmem_arbiter_if.slave -- CPU and loader request/response channels
//           plus the shared memory port
// One access is granted per cycle; ready/stall and the memory drive are
// combinational from the grant, read data returns one cycle after acceptance.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    GNT_C = 1'b0,
    GNT_L = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              l_rvalid_q, l_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

  logic              grant_c;
  logic              grant_l;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Round-robin grant; on a conflict the port not granted last wins.
  // Nothing is granted while reset is held, so no access leaks to memory.
  always_comb begin
    grant_c = 1'b0;
    grant_l = 1'b0;
    if (!reset) begin
      grant_c = bus.c_req && (!bus.l_req || (last_grant_q == GNT_L));
      grant_l = bus.l_req && (!bus.c_req || (last_grant_q == GNT_C));
    end
  end

  // Memory drive from the granted port; idle port is driven to zero.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_c) begin
      mem_read  = !bus.c_we;
      mem_write = bus.c_we;
      mem_addr  = bus.c_addr;
      mem_wdata = bus.c_wdata;
    end else if (grant_l) begin
      mem_read  = !bus.l_we;
      mem_write = bus.l_we;
      mem_addr  = bus.l_addr;
      mem_wdata = bus.l_wdata;
    end
  end

  // Next state: grant history and read-return capture for the owning port.
  always_comb begin
    last_grant_d = last_grant_q;
    c_rvalid_d   = 1'b0;
    l_rvalid_d   = 1'b0;
    c_rdata_d    = c_rdata_q;
    l_rdata_d    = l_rdata_q;
    if (grant_c) begin
      last_grant_d = GNT_C;
      if (!bus.c_we) begin
        c_rvalid_d = 1'b1;
        c_rdata_d  = bus.mem_rdata;
      end
    end else if (grant_l) begin
      last_grant_d = GNT_L;
      if (!bus.l_we) begin
        l_rvalid_d = 1'b1;
        l_rdata_d  = bus.mem_rdata;
      end
    end
  end

  // State registers; reset leaves L as last grant so C wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GNT_L;
      c_rvalid_q   <= 1'b0;
      l_rvalid_q   <= 1'b0;
      c_rdata_q    <= '0;
      l_rdata_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      c_rvalid_q   <= c_rvalid_d;
      l_rvalid_q   <= l_rvalid_d;
      c_rdata_q    <= c_rdata_d;
      l_rdata_q    <= l_rdata_d;
    end
  end

  assign bus.c_ready   = grant_c;
  assign bus.c_stall   = bus.c_req && !grant_c;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.l_ready   = grant_l;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.l_rvalid  = l_rvalid_q;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: fixed preset contents, overridden by writes.
  logic [31:0] mem     [0:63];
  bit          written [0:63];
  logic [5:0]  midx;

  function automatic logic [31:0] preset(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'h20202020;
      32'h40:  return 32'h40404040;
      32'h44:  return 32'h44444444;
      default: return 32'h0;
    endcase
  endfunction

  assign midx = bus.mem_addr[7:2];
  assign bus.mem_rdata = written[midx] ? mem[midx] : preset(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[midx]     <= bus.mem_wdata;
      written[midx] <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.c_req = 1'b1; bus.c_addr = 32'h10;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h8;
    step();
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_c_rvalid: got %b exp 0", bus.c_rvalid); end
    n_checks++; if (bus.l_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_l_rvalid: got %b exp 0", bus.l_rvalid); end
    n_checks++; if (bus.c_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_c_rdata: got %h exp 0", bus.c_rdata); end
    n_checks++; if (bus.l_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_l_rdata: got %h exp 0", bus.l_rdata); end
    n_checks++; if (bus.mem_read !== 1'b0) begin n_errors++; $display("FAIL reset_mem_read: got %b exp 0", bus.mem_read); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_errors++; $display("FAIL reset_mem_write: got %b exp 0", bus.mem_write); end
    idle_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_c_read();
    do_reset();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
    #1;
    n_checks++; if (bus.c_ready !== 1'b1) begin n_errors++; $display("FAIL cread_ready: got %b exp 1", bus.c_ready); end
    n_checks++; if (bus.mem_read !== 1'b1) begin n_errors++; $display("FAIL cread_mem_read: got %b exp 1", bus.mem_read); end
    n_checks++; if (bus.c_stall !== 1'b0) begin n_errors++; $display("FAIL cread_stall: got %b exp 0", bus.c_stall); end
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_errors++; $display("FAIL cread_mem_addr: got %h exp 10", bus.mem_addr); end
    step();
    bus.c_req = 1'b0;
    n_checks++; if (bus.c_rvalid !== 1'b1) begin n_errors++; $display("FAIL cread_rvalid: got %b exp 1", bus.c_rvalid); end
    n_checks++; if (bus.c_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cread_rdata: got %h exp deadbeef", bus.c_rdata); end
    n_checks++; if (bus.l_rvalid !== 1'b0) begin n_errors++; $display("FAIL cread_l_rvalid: got %b exp 0", bus.l_rvalid); end
    step();
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_errors++; $display("FAIL cread_rvalid_pulse: got %b exp 0", bus.c_rvalid); end
    n_checks++; if (bus.c_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cread_rdata_hold: got %h exp deadbeef", bus.c_rdata); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h20;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h24; bus.l_wdata = 32'hCAFE0001;
    #1;
    n_checks++; if (bus.c_ready !== 1'b1) begin n_errors++; $display("FAIL sim0_c_ready: got %b exp 1", bus.c_ready); end
    n_checks++; if (bus.c_stall !== 1'b0) begin n_errors++; $display("FAIL sim0_c_stall: got %b exp 0", bus.c_stall); end
    n_checks++; if (bus.l_ready !== 1'b0) begin n_errors++; $display("FAIL sim0_l_ready: got %b exp 0", bus.l_ready); end
    step();
    // C issues a second read of 0x20 and must lose this cycle
    #1;
    n_checks++; if (bus.l_ready !== 1'b1) begin n_errors++; $display("FAIL sim1_l_ready: got %b exp 1", bus.l_ready); end
    n_checks++; if (bus.c_stall !== 1'b1) begin n_errors++; $display("FAIL sim1_c_stall: got %b exp 1", bus.c_stall); end
    n_checks++; if (bus.mem_write !== 1'b1) begin n_errors++; $display("FAIL sim1_mem_write: got %b exp 1", bus.mem_write); end
    n_checks++; if (bus.mem_addr !== 32'h24) begin n_errors++; $display("FAIL sim1_mem_addr: got %h exp 24", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'hCAFE0001) begin n_errors++; $display("FAIL sim1_mem_wdata: got %h exp cafe0001", bus.mem_wdata); end
    n_checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h20202020) begin n_errors++; $display("FAIL sim1_c_rdata: got %b/%h exp 1/20202020", bus.c_rvalid, bus.c_rdata); end
    step();
    bus.l_req = 1'b0;
    #1;
    n_checks++; if (bus.l_rvalid !== 1'b0) begin n_errors++; $display("FAIL sim2_l_rvalid_write: got %b exp 0", bus.l_rvalid); end
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_errors++; $display("FAIL sim2_c_rvalid: got %b exp 0", bus.c_rvalid); end
    n_checks++; if (bus.c_ready !== 1'b1) begin n_errors++; $display("FAIL sim2_c_ready: got %b exp 1", bus.c_ready); end
    step();
    bus.c_addr = 32'h24;
    #1;
    n_checks++; if (bus.c_ready !== 1'b1) begin n_errors++; $display("FAIL sim3_c_ready: got %b exp 1", bus.c_ready); end
    step();
    bus.c_req = 1'b0;
    n_checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'hCAFE0001) begin n_errors++; $display("FAIL sim4_readback: got %b/%h exp 1/cafe0001", bus.c_rvalid, bus.c_rdata); end
  endtask

  task automatic test_dual_reads();
    logic exp_c;
    do_reset();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h40;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h44;
    for (int i = 0; i < 6; i++) begin
      exp_c = (i % 2 == 0);
      #1;
      n_checks++; if (bus.c_ready !== exp_c) begin n_errors++; $display("FAIL dual%0d_c_ready: got %b exp %b", i, bus.c_ready, exp_c); end
      n_checks++; if (bus.l_ready !== !exp_c) begin n_errors++; $display("FAIL dual%0d_l_ready: got %b exp %b", i, bus.l_ready, !exp_c); end
      n_checks++; if (bus.c_stall !== !exp_c) begin n_errors++; $display("FAIL dual%0d_c_stall: got %b exp %b", i, bus.c_stall, !exp_c); end
      step();
      n_checks++; if (bus.c_rvalid !== exp_c) begin n_errors++; $display("FAIL dual%0d_c_rvalid: got %b exp %b", i, bus.c_rvalid, exp_c); end
      n_checks++; if (bus.l_rvalid !== !exp_c) begin n_errors++; $display("FAIL dual%0d_l_rvalid: got %b exp %b", i, bus.l_rvalid, !exp_c); end
      if (exp_c) begin
        n_checks++; if (bus.c_rdata !== 32'h40404040) begin n_errors++; $display("FAIL dual%0d_c_rdata: got %h exp 40404040", i, bus.c_rdata); end
      end else begin
        n_checks++; if (bus.l_rdata !== 32'h44444444) begin n_errors++; $display("FAIL dual%0d_l_rdata: got %h exp 44444444", i, bus.l_rdata); end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_l_write();
    do_reset();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h8; bus.l_wdata = 32'h12345678;
    #1;
    n_checks++; if (bus.l_ready !== 1'b1) begin n_errors++; $display("FAIL lwr_l_ready: got %b exp 1", bus.l_ready); end
    n_checks++; if (bus.mem_write !== 1'b1) begin n_errors++; $display("FAIL lwr_mem_write: got %b exp 1", bus.mem_write); end
    n_checks++; if (bus.mem_read !== 1'b0) begin n_errors++; $display("FAIL lwr_mem_read: got %b exp 0", bus.mem_read); end
    n_checks++; if (bus.mem_wdata !== 32'h12345678) begin n_errors++; $display("FAIL lwr_mem_wdata: got %h exp 12345678", bus.mem_wdata); end
    step();
    bus.l_req = 1'b0;
    #1;
    n_checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin n_errors++; $display("FAIL lwr_after_mem: got %b/%b exp 0/0", bus.mem_write, bus.mem_read); end
    n_checks++; if (bus.c_rvalid !== 1'b0 || bus.l_rvalid !== 1'b0) begin n_errors++; $display("FAIL lwr_rvalid: got %b/%b exp 0/0", bus.c_rvalid, bus.l_rvalid); end
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h8;
    step();
    bus.c_req = 1'b0;
    n_checks++; if (bus.c_rdata !== 32'h12345678) begin n_errors++; $display("FAIL lwr_readback: got %h exp 12345678", bus.c_rdata); end
  endtask

  task automatic test_idle();
    do_reset();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
    step();
    bus.c_req = 1'b0; bus.c_addr = '0;
    #1;
    n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_errors++; $display("FAIL idle_mem_rw: got %b/%b exp 0/0", bus.mem_read, bus.mem_write); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_errors++; $display("FAIL idle_mem_addr: got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.c_ready !== 1'b0 || bus.l_ready !== 1'b0) begin n_errors++; $display("FAIL idle_ready: got %b/%b exp 0/0", bus.c_ready, bus.l_ready); end
    step();
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_errors++; $display("FAIL idle_c_rvalid: got %b exp 0", bus.c_rvalid); end
    // C was last granted before the idle cycle, so L wins this conflict
    bus.c_req = 1'b1; bus.c_addr = 32'h10;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h44;
    #1;
    n_checks++; if (bus.l_ready !== 1'b1 || bus.c_ready !== 1'b0) begin n_errors++; $display("FAIL idle_conflict: got l=%b c=%b exp l=1 c=0", bus.l_ready, bus.c_ready); end
    n_checks++; if (bus.c_stall !== 1'b1) begin n_errors++; $display("FAIL idle_conflict_stall: got %b exp 1", bus.c_stall); end
    step();
    idle_inputs();
    n_checks++; if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 32'h44444444) begin n_errors++; $display("FAIL idle_l_rdata: got %b/%h exp 1/44444444", bus.l_rvalid, bus.l_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
    step();
    n_checks++; if (bus.c_rvalid !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_rvalid: got %b exp 1", bus.c_rvalid); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_errors++; $display("FAIL rmid_rvalid: got %b exp 0", bus.c_rvalid); end
    n_checks++; if (bus.c_rdata !== 32'h0) begin n_errors++; $display("FAIL rmid_rdata: got %h exp 0", bus.c_rdata); end
    n_checks++; if (bus.mem_read !== 1'b0) begin n_errors++; $display("FAIL rmid_mem_read: got %b exp 0", bus.mem_read); end
    step();
    reset = 1'b0;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h44;
    #1;
    n_checks++; if (bus.c_ready !== 1'b1 || bus.l_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_conflict: got c=%b l=%b exp c=1 l=0", bus.c_ready, bus.l_ready); end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_c_read();
    test_simultaneous();
    test_dual_reads();
    test_l_write();
    test_idle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
